matrix3_3_window_ctrl: RTL and testbench

//   Sequencer for the 1-bit 3x3 line-buffer window generator. Tracks frame/line position
//   of incoming pixels and drives the generator's write enable. Primes the two line

---
 rtl/matrix3_3_window_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_matrix3_3_window_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix3_3_window_ctrl.sv
// matrix3_3_window_ctrl
// Sequencer for the 1-bit 3x3 line-buffer window generator. It follows the frame/line
// position of incoming pixels and drives the generator write enable. It primes the two
// line buffers, flushes the final line with pad shifts, and tags each emitted window with
// its centre row/col and a border flag. The tags arrive after a WIN_LAT-deep delay, so
// they line up with the generator's matrix registers.
//
// Build option: define WIN_BORDER_PASS_EN to emit every window and flag the edge centres.
// When the macro is undefined, windows whose centre lies on the border are suppressed, so
// only interior windows come out, and o_win_border is tied to 0. The shift/pad sequence
// is the same in both builds.

module matrix3_3_window_ctrl #(
    parameter int unsigned IMG_W   = 800,
    parameter int unsigned IMG_H   = 600,
    parameter int unsigned WIN_LAT = 3
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_vsync_in,
    input  logic        i_pix_vld,
    output logic        o_lb_shift_en,
    output logic        o_lb_pad,
    output logic        o_win_vld,
    output logic [11:0] o_win_row,
    output logic [11:0] o_win_col,
    output logic        o_win_border,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam logic [11:0] ColLast   = 12'(IMG_W - 1);
    localparam logic [11:0] RowLast   = 12'(IMG_H - 1);
    localparam logic [11:0] FlushLast = 12'(IMG_W);
    // Marks the output stage. A window sitting there is already visible, so the frame
    // can be reported done.
    localparam logic [WIN_LAT-1:0] OutStage = WIN_LAT'(1) << (WIN_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_vsync_d;

    logic [11:0] r_in_col;
    logic [11:0] r_in_row;
    logic [11:0] r_ctr_col;
    logic [11:0] r_ctr_row;
    logic [11:0] r_flush_cnt;

    // r_q_pipe tracks every queued window, including suppressed ones, so it can drain the
    // frame. r_v_pipe tracks only the windows that become visible.
    logic [WIN_LAT-1:0] r_q_pipe;
    logic [WIN_LAT-1:0] r_v_pipe;
    logic [11:0]        r_row_pipe [WIN_LAT];
    logic [11:0]        r_col_pipe [WIN_LAT];

    logic w_vsync_rise;
    logic w_abort;
    logic w_accept;
    logic w_pad_shift;
    logic w_queue;
    logic w_vis;
    logic w_prime_end;
    logic w_run_end;
    logic w_flush_end;
    logic w_ctr_border;
    logic w_pipe_pending;

    assign w_vsync_rise = i_vsync_in & ~r_vsync_d;
    assign w_abort      = w_vsync_rise & (r_state != StIdle);

    // A pixel that arrives in the same cycle as a vsync rise belongs to no frame. It is
    // never shifted.
    assign w_accept    = i_pix_vld & ~w_vsync_rise &
                         ((r_state == StPrime) | (r_state == StRun));
    assign w_pad_shift = ~w_vsync_rise & (r_state == StFlush);
    assign w_queue     = (w_accept & (r_state == StRun)) | w_pad_shift;

    // Priming ends on the (IMG_W+1)th pixel, which is the first pixel of line 1.
    assign w_prime_end = w_accept & (r_state == StPrime) &
                         (r_in_row == 12'd1) & (r_in_col == 12'd0);
    assign w_run_end   = w_accept & (r_state == StRun) &
                         (r_in_row == RowLast) & (r_in_col == ColLast);
    assign w_flush_end = w_pad_shift & (r_flush_cnt == FlushLast);

    assign w_ctr_border = (r_ctr_row == 12'd0) | (r_ctr_row == RowLast) |
                          (r_ctr_col == 12'd0) | (r_ctr_col == ColLast);

    assign w_pipe_pending = |(r_q_pipe & ~OutStage);

`ifdef WIN_BORDER_PASS_EN
    assign w_vis = w_queue;
`else
    assign w_vis = w_queue & ~w_ctr_border;
`endif

    assign o_lb_shift_en = w_accept | w_pad_shift;
    assign o_lb_pad      = w_pad_shift;
    assign o_busy        = (r_state != StIdle);
    assign o_frame_err   = w_abort |
                           (i_pix_vld & ((r_state == StFlush) | (r_state == StDone)));
    assign o_win_vld     = r_v_pipe[WIN_LAT-1];
    assign o_win_row     = r_row_pipe[WIN_LAT-1];
    assign o_win_col     = r_col_pipe[WIN_LAT-1];

    // State register and vsync edge-detect flop
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state   <= StIdle;
            r_vsync_d <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_vsync_d <= i_vsync_in;
        end
    end

    // Next-state decode and the frame_done pulse
    always_comb begin
        w_state_next = r_state;
        o_frame_done = 1'b0;
        if (w_vsync_rise) begin
            // Any vsync rise starts a new frame. Outside IDLE, it abandons the current frame.
            w_state_next = StPrime;
        end else begin
            case (r_state)
                StIdle:  w_state_next = StIdle;
                StPrime: if (w_prime_end) w_state_next = StRun;
                StRun:   if (w_run_end)   w_state_next = StFlush;
                StFlush: if (w_flush_end) w_state_next = StDone;
                StDone: begin
                    if (!w_pipe_pending) begin
                        o_frame_done = 1'b1;
                        w_state_next = StIdle;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Input position, centre position and flush counters. All are cleared on frame start.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_ctr_col   <= '0;
            r_ctr_row   <= '0;
            r_flush_cnt <= '0;
        end else if (w_vsync_rise) begin
            r_in_col    <= '0;
            r_in_row    <= '0;
            r_ctr_col   <= '0;
            r_ctr_row   <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                if (r_in_col == ColLast) begin
                    r_in_col <= '0;
                    r_in_row <= r_in_row + 12'd1;
                end else begin
                    r_in_col <= r_in_col + 12'd1;
                end
            end
            if (w_queue) begin
                if (r_ctr_col == ColLast) begin
                    r_ctr_col <= '0;
                    r_ctr_row <= r_ctr_row + 12'd1;
                end else begin
                    r_ctr_col <= r_ctr_col + 12'd1;
                end
            end
            if (w_pad_shift) begin
                r_flush_cnt <= r_flush_cnt + 12'd1;
            end
        end
    end

    // Valid delay pipe. An abort drops every window still in flight.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_q_pipe <= '0;
            r_v_pipe <= '0;
        end else if (w_abort) begin
            r_q_pipe <= '0;
            r_v_pipe <= '0;
        end else begin
            r_q_pipe <= WIN_LAT'({r_q_pipe, w_queue});
            r_v_pipe <= WIN_LAT'({r_v_pipe, w_vis});
        end
    end

    // Position tag pipe. A stage loads only behind a visible window, so the outputs hold
    // the last emitted window between windows.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            for (int i = 0; i < int'(WIN_LAT); i++) begin
                r_row_pipe[i] <= '0;
                r_col_pipe[i] <= '0;
            end
        end else if (!w_abort) begin
            if (w_vis) begin
                r_row_pipe[0] <= r_ctr_row;
                r_col_pipe[0] <= r_ctr_col;
            end
            for (int i = 1; i < int'(WIN_LAT); i++) begin
                if (r_v_pipe[i-1]) begin
                    r_row_pipe[i] <= r_row_pipe[i-1];
                    r_col_pipe[i] <= r_col_pipe[i-1];
                end
            end
        end
    end

`ifdef WIN_BORDER_PASS_EN
    logic r_bdr_pipe [WIN_LAT];

    assign o_win_border = r_bdr_pipe[WIN_LAT-1];

    // Border-flag pipe, which runs alongside the position tags
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            for (int i = 0; i < int'(WIN_LAT); i++) begin
                r_bdr_pipe[i] <= 1'b0;
            end
        end else if (!w_abort) begin
            if (w_vis) begin
                r_bdr_pipe[0] <= w_ctr_border;
            end
            for (int i = 1; i < int'(WIN_LAT); i++) begin
                if (r_v_pipe[i-1]) begin
                    r_bdr_pipe[i] <= r_bdr_pipe[i-1];
                end
            end
        end
    end
`else
    assign o_win_border = 1'b0;
`endif

endmodule

// File: tb/tb_matrix3_3_window_ctrl.sv
// Directed bench for matrix3_3_window_ctrl at IMG_W=8, IMG_H=4, WIN_LAT=3.
// A negedge monitor logs shifts, windows, done and error pulses into queues. The main
// sequence takes queue offsets at frame boundaries and checks each frame against a
// raster-order model of the expected centres.

module tb_matrix3_3_window_ctrl;

    localparam int W = 8;
    localparam int H = 4;
    localparam int L = 3;
`ifdef WIN_BORDER_PASS_EN
    localparam bit Pass = 1'b1;
`else
    localparam bit Pass = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        vsync;
    logic        pix;
    logic        shift_en;
    logic        pad;
    logic        win_vld;
    logic [11:0] win_row;
    logic [11:0] win_col;
    logic        win_border;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    int sh_cyc[$];
    bit sh_pad[$];
    int w_cyc[$];
    int w_row_q[$];
    int w_col_q[$];
    bit w_bdr_q[$];
    int d_cyc[$];
    int e_cyc[$];

    matrix3_3_window_ctrl #(
        .IMG_W   (W),
        .IMG_H   (H),
        .WIN_LAT (L)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst     (rst),
        .i_vsync_in    (vsync),
        .i_pix_vld     (pix),
        .o_lb_shift_en (shift_en),
        .o_lb_pad      (pad),
        .o_win_vld     (win_vld),
        .o_win_row     (win_row),
        .o_win_col     (win_col),
        .o_win_border  (win_border),
        .o_frame_done  (frame_done),
        .o_frame_err   (frame_err),
        .o_busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (shift_en === 1'b1) begin
            sh_cyc.push_back(cyc);
            sh_pad.push_back(pad);
        end
        if (win_vld === 1'b1) begin
            w_cyc.push_back(cyc);
            w_row_q.push_back(int'(win_row));
            w_col_q.push_back(int'(win_col));
            w_bdr_q.push_back(win_border);
        end
        if (frame_done === 1'b1) d_cyc.push_back(cyc);
        if (frame_err === 1'b1) e_cyc.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " lb_shift_en"}, 32'(shift_en), 0);
        chk({tag, " lb_pad"}, 32'(pad), 0);
        chk({tag, " win_vld"}, 32'(win_vld), 0);
        chk({tag, " win_row"}, 32'(win_row), 0);
        chk({tag, " win_col"}, 32'(win_col), 0);
        chk({tag, " win_border"}, 32'(win_border), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
        chk({tag, " frame_err"}, 32'(frame_err), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    // Each frame should produce W*H pixel shifts and then W+1 pad shifts. Window k in
    // raster order is queued by shift k+W+1 and should appear L cycles after that shift.
    task automatic check_frame(input string tag, input int sb, input int wb, input int db,
                               input int eb, input int exp_err);
        int nsh;
        int npad_head;
        int npad_tail;
        int j;
        int idx;
        int si;
        int wi;
        int exp_t;
        bit bdr;
        nsh = sh_cyc.size() - sb;
        chk({tag, " shift count"}, nsh, W * H + W + 1);
        npad_head = 0;
        npad_tail = 0;
        for (int k = sb; k < sh_cyc.size(); k++) begin
            if (sh_pad[k]) begin
                if (k - sb < W * H) npad_head++;
                else npad_tail++;
            end
        end
        chk({tag, " pads among pixel shifts"}, npad_head, 0);
        chk({tag, " trailing pad shifts"}, npad_tail, W + 1);
        j = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                idx = r * W + c;
                bdr = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
                if (Pass || !bdr) begin
                    wi = wb + j;
                    si = sb + idx + W + 1;
                    if (wi < w_cyc.size()) begin
                        exp_t = (si < sh_cyc.size()) ? sh_cyc[si] + L : -1;
                        chk($sformatf("%s win%0d row", tag, j), w_row_q[wi], r);
                        chk($sformatf("%s win%0d col", tag, j), w_col_q[wi], c);
                        chk($sformatf("%s win%0d border", tag, j), 32'(w_bdr_q[wi]),
                            32'(Pass && bdr));
                        chk($sformatf("%s win%0d cycle", tag, j), w_cyc[wi], exp_t);
                    end
                    j++;
                end
            end
        end
        chk({tag, " window count"}, w_cyc.size() - wb, j);
        chk({tag, " frame_done count"}, d_cyc.size() - db, 1);
        if (d_cyc.size() > db && sh_cyc.size() > sb) begin
            chk({tag, " frame_done cycle"}, d_cyc[db], sh_cyc[sh_cyc.size() - 1] + L);
        end
        chk({tag, " frame_err count"}, e_cyc.size() - eb, exp_err);
    endtask

    initial begin
        int sb;
        int wb;
        int db;
        int eb;
        int sent;

        rst   = 1'b1;
        vsync = 1'b0;
        pix   = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk_outputs_zero("reset");
        step();
        rst = 1'b0;
        repeat (2) step();

        // Back-to-back frame. The pixel in the vsync cycle must be ignored.
        sb = sh_cyc.size(); wb = w_cyc.size(); db = d_cyc.size(); eb = e_cyc.size();
        step();
        vsync = 1'b1;
        pix   = 1'b1;
        @(negedge clk);
        chk("idle pixel with vsync not shifted", 32'(shift_en), 0);
        step();
        vsync = 1'b0;
        @(negedge clk);
        chk("busy after start", 32'(busy), 1);
        repeat (31) step();
        step();
        pix = 1'b0;
        repeat (20) step();
        check_frame("b2b", sb, wb, db, eb, 0);
        @(negedge clk);
        chk("busy after frame", 32'(busy), 0);

        // Frame with random gaps between pixels
        step();
        sb = sh_cyc.size(); wb = w_cyc.size(); db = d_cyc.size(); eb = e_cyc.size();
        vsync = 1'b1;
        pix   = 1'b0;
        step();
        vsync = 1'b0;
        sent  = 0;
        for (int k = 0; k < 400 && sent < W * H; k++) begin
            pix = 1'($urandom_range(0, 1));
            if (pix) sent++;
            step();
        end
        pix = 1'b0;
        repeat (20) step();
        check_frame("gaps", sb, wb, db, eb, 0);

        // Abort after 20 pixels, then a full frame
        sb = sh_cyc.size(); wb = w_cyc.size(); db = d_cyc.size(); eb = e_cyc.size();
        step();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        pix   = 1'b1;
        repeat (19) step();
        step();
        vsync = 1'b1;
        pix   = 1'b0;
        @(negedge clk);
        chk("abort frame_err", 32'(frame_err), 1);
        chk("abort frame_done", 32'(frame_done), 0);
        step();
        vsync = 1'b0;
        pix   = 1'b1;
        chk("aborted frame_done count", d_cyc.size() - db, 0);
        chk("aborted frame_err count", e_cyc.size() - eb, 1);
        sb = sh_cyc.size(); wb = w_cyc.size(); db = d_cyc.size(); eb = e_cyc.size();
        repeat (31) step();
        step();
        pix = 1'b0;
        repeat (20) step();
        check_frame("restart", sb, wb, db, eb, 0);

        // One pixel arrives during FLUSH
        sb = sh_cyc.size(); wb = w_cyc.size(); db = d_cyc.size(); eb = e_cyc.size();
        step();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        pix   = 1'b1;
        repeat (31) step();
        step();
        @(negedge clk);
        chk("flush pixel pad", 32'(pad), 1);
        chk("flush pixel frame_err", 32'(frame_err), 1);
        step();
        pix = 1'b0;
        repeat (20) step();
        check_frame("flushpix", sb, wb, db, eb, 1);

        // Reset in the middle of RUN
        step();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        pix   = 1'b1;
        repeat (12) step();
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrun reset");
        step();
        rst = 1'b0;
        sb = sh_cyc.size(); wb = w_cyc.size(); db = d_cyc.size();
        repeat (15) step();
        pix = 1'b0;
        step();
        chk("post-reset shifts", sh_cyc.size() - sb, 0);
        chk("post-reset windows", w_cyc.size() - wb, 0);
        chk("post-reset frame_done", d_cyc.size() - db, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
